system_ctrl_stack: RTL and testbench

//  Next-generation system register block for cpu32e2. Holds flags, interrupt enable, exception/IRQ masks,
//  ISR base, syscall number, EPC and cause. Adds a nested trap save/restore stack and edge-captured

---
 rtl/system_ctrl_stack_if.sv | 19 +
 rtl/system_ctrl_stack.sv | 191 +++++++++++++++++++
 tb/tb_system_ctrl_stack.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_ctrl_stack_if.sv
// CSR access bus between the sys-register instruction path and the system register block.
// The master drives write/read requests; the slave returns combinational read data.
interface system_ctrl_stack_if;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr;
  logic [31:0] read_data;

  modport master (
    output write_en, write_addr, write_data, read_addr,
    input  read_data
  );

  modport slave (
    input  write_en, write_addr, write_data, read_addr,
    output read_data
  );
endinterface

// File: rtl/system_ctrl_stack.sv
// System register block for cpu32e2: flags, interrupt control, IRQ capture, EPC/cause and a
// nested trap save/restore stack that is pushed on trap entry and popped on trap return.
module system_ctrl_stack #(
  parameter int          FLAG_W      = 4,
  parameter int          SYSCALL_W   = 6,
  parameter int          NUM_IRQ     = 8,
  parameter int          STACK_DEPTH = 4,
  parameter logic [31:0] RESET_ISR   = 32'd4,
  localparam int         DW          = $clog2(STACK_DEPTH) + 1,
  localparam int         IW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  system_ctrl_stack_if.slave   bus,
  input  logic                 exception_pending,
  input  logic                 flags_en,
  input  logic [FLAG_W-1:0]    flags_in,
  input  logic                 syscall_en,
  input  logic [SYSCALL_W-1:0] syscall_num,
  input  logic                 int_en_set,
  input  logic                 int_en_clr,
  input  logic                 trap_entry,
  input  logic                 trap_return,
  input  logic [4:0]           trap_cause,
  input  logic [31:0]          trap_pc,
  input  logic [NUM_IRQ-1:0]   irq_lines,
  output logic                 interrupt_enable,
  output logic [15:0]          exception_mask,
  output logic [FLAG_W-1:0]    flags,
  output logic [31:0]          isr_base_address,
  output logic [31:0]          epc,
  output logic                 irq_request,
  output logic [IW-1:0]        irq_id,
  output logic [DW-1:0]        nest_depth
);
  localparam int          SW        = $clog2(STACK_DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [NUM_IRQ-1:0]   irq_mask;
  logic [NUM_IRQ-1:0]   irq_pending;
  logic [NUM_IRQ-1:0]   irq_prev;
  logic [SYSCALL_W-1:0] syscall;
  logic [4:0]           cause;
  logic                 overflow;
  logic                 underflow;

  logic [FLAG_W-1:0] stk_flags [STACK_DEPTH];
  logic              stk_ie    [STACK_DEPTH];
  logic [4:0]        stk_cause [STACK_DEPTH];
  logic [31:0]       stk_epc   [STACK_DEPTH];

  logic          csr_wr;
  logic          wr_flags, wr_ctrl, wr_isr, wr_mask, wr_pend, wr_epc, wr_stat;
  logic          push, pop, ret_empty, entry_full;
  logic [SW-1:0] push_slot, top_slot;
  logic [NUM_IRQ-1:0] active;
  logic [31:0]   rd;

  assign csr_wr   = bus.write_en & ~exception_pending;
  assign wr_flags = csr_wr && (bus.write_addr == 5'd0);
  assign wr_ctrl  = csr_wr && (bus.write_addr == 5'd1);
  assign wr_isr   = csr_wr && (bus.write_addr == 5'd2);
  assign wr_mask  = csr_wr && (bus.write_addr == 5'd4);
  assign wr_pend  = csr_wr && (bus.write_addr == 5'd5);
  assign wr_epc   = csr_wr && (bus.write_addr == 5'd6);
  assign wr_stat  = csr_wr && (bus.write_addr == 5'd7);

  // Entry always wins over a simultaneous return.
  assign push       = trap_entry && (nest_depth < DEPTH_MAX);
  assign entry_full = trap_entry && (nest_depth == DEPTH_MAX);
  assign pop        = trap_return && !trap_entry && (nest_depth != '0);
  assign ret_empty  = trap_return && !trap_entry && (nest_depth == '0);
  assign push_slot  = nest_depth[SW-1:0];
  assign top_slot   = SW'(nest_depth - DW'(1));

  always_ff @(posedge clk) begin
    if (reset && push) begin
      stk_flags[push_slot] <= flags;
      stk_ie[push_slot]    <= interrupt_enable;
      stk_cause[push_slot] <= cause;
      stk_epc[push_slot]   <= epc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags            <= '0;
      interrupt_enable <= 1'b0;
      exception_mask   <= '0;
      irq_mask         <= '0;
      irq_pending      <= '0;
      irq_prev         <= '0;
      isr_base_address <= RESET_ISR;
      syscall          <= '0;
      cause            <= '0;
      epc              <= '0;
      nest_depth       <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      if (pop)
        flags <= stk_flags[top_slot];
      else if (wr_flags)
        flags <= bus.write_data[FLAG_W-1:0];
      else if (flags_en && !exception_pending)
        flags <= flags_in;

      if (trap_entry)
        interrupt_enable <= 1'b0;
      else if (pop)
        interrupt_enable <= stk_ie[top_slot];
      else if (ret_empty)
        interrupt_enable <= 1'b1;
      else if (wr_ctrl)
        interrupt_enable <= bus.write_data[15];
      else if (!exception_pending && int_en_clr)
        interrupt_enable <= 1'b0;
      else if (!exception_pending && int_en_set)
        interrupt_enable <= 1'b1;

      if (trap_entry)
        cause <= trap_cause;
      else if (pop)
        cause <= stk_cause[top_slot];
      else if (wr_ctrl)
        cause <= bus.write_data[4:0];

      if (trap_entry)
        epc <= trap_pc;
      else if (pop)
        epc <= stk_epc[top_slot];
      else if (wr_epc)
        epc <= bus.write_data;

      if (wr_ctrl) exception_mask <= bus.write_data[31:16];
      if (wr_isr) isr_base_address <= bus.write_data;
      if (wr_mask) irq_mask <= bus.write_data[NUM_IRQ-1:0];
      if (syscall_en) syscall <= syscall_num;

      // A fresh rising edge survives a same-cycle write-1-to-clear.
      irq_prev    <= irq_lines;
      irq_pending <= (irq_pending & ~(wr_pend ? bus.write_data[NUM_IRQ-1:0] : '0))
                   | (irq_lines & ~irq_prev);

      if (push)
        nest_depth <= nest_depth + DW'(1);
      else if (pop)
        nest_depth <= nest_depth - DW'(1);

      if (entry_full)
        overflow <= 1'b1;
      else if (wr_stat && bus.write_data[0])
        overflow <= 1'b0;

      if (ret_empty)
        underflow <= 1'b1;
      else if (wr_stat && bus.write_data[1])
        underflow <= 1'b0;
    end
  end

  assign active      = irq_pending & irq_mask;
  assign irq_request = interrupt_enable & (|active);

  always_comb begin
    irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) irq_id = IW'(i);
  end

  always_comb begin
    rd = '0;
    case (bus.read_addr)
      5'd0: rd[FLAG_W-1:0] = flags;
      5'd1: rd = {exception_mask, interrupt_enable, 10'b0, cause};
      5'd2: rd = isr_base_address;
      5'd3: rd[SYSCALL_W-1:0] = syscall;
      5'd4: rd[NUM_IRQ-1:0] = irq_mask;
      5'd5: rd[NUM_IRQ-1:0] = irq_pending;
      5'd6: rd = epc;
      5'd7: begin
        rd[16 +: DW] = nest_depth;
        rd[1]        = underflow;
        rd[0]        = overflow;
      end
      default: rd = '0;
    endcase
  end

  assign bus.read_data = rd;
endmodule

// File: tb/tb_system_ctrl_stack.sv
// Bench for system_ctrl_stack: directed scenarios followed by randomized traffic, all compared
// against a queue-based reference model of the register block.
module tb_system_ctrl_stack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  system_ctrl_stack_if bus ();

  logic        exception_pending, flags_en, syscall_en, int_en_set, int_en_clr;
  logic        trap_entry, trap_return;
  logic [3:0]  flags_in;
  logic [5:0]  syscall_num;
  logic [4:0]  trap_cause;
  logic [31:0] trap_pc;
  logic [7:0]  irq_lines;
  logic        interrupt_enable, irq_request;
  logic [15:0] exception_mask;
  logic [3:0]  flags;
  logic [31:0] isr_base_address, epc;
  logic [2:0]  irq_id, nest_depth;

  int n_checks = 0;
  int n_errors = 0;

  system_ctrl_stack dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .exception_pending(exception_pending), .flags_en(flags_en), .flags_in(flags_in),
    .syscall_en(syscall_en), .syscall_num(syscall_num),
    .int_en_set(int_en_set), .int_en_clr(int_en_clr),
    .trap_entry(trap_entry), .trap_return(trap_return),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .irq_lines(irq_lines),
    .interrupt_enable(interrupt_enable), .exception_mask(exception_mask), .flags(flags),
    .isr_base_address(isr_base_address), .epc(epc), .irq_request(irq_request),
    .irq_id(irq_id), .nest_depth(nest_depth)
  );

  // Reference model state; the trap stack is a queue of saved frames.
  typedef struct packed {
    logic [3:0]  f;
    logic        ie;
    logic [4:0]  c;
    logic [31:0] pc;
  } frame_t;

  frame_t      stk[$];
  logic [3:0]  m_flags = '0;
  logic        m_ie = 1'b0, m_of = 1'b0, m_uf = 1'b0;
  logic [15:0] m_mask = '0;
  logic [7:0]  m_irqmask = '0, m_pend = '0, m_prev = '0;
  logic [31:0] m_isr = 32'd4, m_epc = '0;
  logic [5:0]  m_sys = '0;
  logic [4:0]  m_cause = '0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0: return {28'b0, m_flags};
      5'd1: return {m_mask, m_ie, 10'b0, m_cause};
      5'd2: return m_isr;
      5'd3: return {26'b0, m_sys};
      5'd4: return {24'b0, m_irqmask};
      5'd5: return {24'b0, m_pend};
      5'd6: return m_epc;
      5'd7: return {13'b0, 3'(stk.size()), 14'b0, m_uf, m_of};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int m_irq_id();
    int r = 0;
    for (int i = 7; i >= 0; i--)
      if (m_pend[i] && m_irqmask[i]) r = i;
    return r;
  endfunction

  // Next state: apply lowest-priority effects first, let higher-priority ones overwrite.
  task automatic model_step();
    logic [3:0]  nf;
    logic        nie, nof, nuf;
    logic [15:0] nmask;
    logic [7:0]  nirq, npend;
    logic [31:0] nisr, nepc;
    logic [5:0]  nsys;
    logic [4:0]  nc;
    frame_t      fr;
    if (!reset) begin
      m_flags = '0; m_ie = 0; m_mask = '0; m_irqmask = '0; m_pend = '0; m_prev = '0;
      m_isr = 32'd4; m_sys = '0; m_cause = '0; m_epc = '0; m_of = 0; m_uf = 0;
      stk.delete();
      return;
    end
    nf = m_flags; nie = m_ie; nof = m_of; nuf = m_uf; nmask = m_mask; nirq = m_irqmask;
    npend = m_pend; nisr = m_isr; nepc = m_epc; nsys = m_sys; nc = m_cause;
    if (!exception_pending) begin
      if (flags_en) nf = flags_in;
      if (int_en_set) nie = 1'b1;
      if (int_en_clr) nie = 1'b0;
    end
    if (bus.write_en && !exception_pending) begin
      case (bus.write_addr)
        5'd0: nf = bus.write_data[3:0];
        5'd1: begin nmask = bus.write_data[31:16]; nie = bus.write_data[15]; nc = bus.write_data[4:0]; end
        5'd2: nisr = bus.write_data;
        5'd4: nirq = bus.write_data[7:0];
        5'd5: npend = npend & ~bus.write_data[7:0];
        5'd6: nepc = bus.write_data;
        5'd7: begin if (bus.write_data[0]) nof = 1'b0; if (bus.write_data[1]) nuf = 1'b0; end
        default: ;
      endcase
    end
    npend = npend | (irq_lines & ~m_prev);
    if (syscall_en) nsys = syscall_num;
    if (trap_entry) begin
      if (stk.size() < 4) begin
        fr.f = m_flags; fr.ie = m_ie; fr.c = m_cause; fr.pc = m_epc;
        stk.push_back(fr);
      end else nof = 1'b1;
      nc = trap_cause; nepc = trap_pc; nie = 1'b0;
    end else if (trap_return) begin
      if (stk.size() > 0) begin
        fr = stk.pop_back();
        nf = fr.f; nie = fr.ie; nc = fr.c; nepc = fr.pc;
      end else begin
        nie = 1'b1; nuf = 1'b1;
      end
    end
    m_flags = nf; m_ie = nie; m_of = nof; m_uf = nuf; m_mask = nmask; m_irqmask = nirq;
    m_pend = npend; m_isr = nisr; m_epc = nepc; m_sys = nsys; m_cause = nc; m_prev = irq_lines;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #1;
    chk("read_data", bus.read_data, m_read(bus.read_addr));
    chk("interrupt_enable", 32'(interrupt_enable), 32'(m_ie));
    chk("exception_mask", 32'(exception_mask), 32'(m_mask));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("isr_base_address", isr_base_address, m_isr);
    chk("epc", epc, m_epc);
    chk("irq_request", 32'(irq_request), 32'(m_ie && ((m_pend & m_irqmask) != 8'h00)));
    chk("irq_id", 32'(irq_id), 32'(m_irq_id()));
    chk("nest_depth", 32'(nest_depth), 32'(stk.size()));
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      bus.read_addr = 5'(a);
      #1;
      chk($sformatf("csr%0d", a), bus.read_data, m_read(5'(a)));
    end
  endtask

  task automatic clear_pulses();
    bus.write_en = 0; bus.write_addr = '0; bus.write_data = '0;
    exception_pending = 0; flags_en = 0; syscall_en = 0; int_en_set = 0; int_en_clr = 0;
    trap_entry = 0; trap_return = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
    bus.write_en = 1'b1; bus.write_addr = a; bus.write_data = d;
  endtask

  initial begin
    clear_pulses();
    flags_in = '0; syscall_num = '0; trap_cause = '0; trap_pc = '0; irq_lines = '0;
    bus.read_addr = '0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;

    read_all();
    check_all();
    bus.read_addr = 5'd2; #1;
    chk("reset_isr", bus.read_data, 32'h4);
    chk("reset_depth", 32'(nest_depth), 32'd0);

    // Control write blocked by a pending exception, then accepted.
    csr_write(5'd1, 32'hABCD8000); exception_pending = 1'b1;
    step(); check_all();
    chk("blocked_mask", 32'(exception_mask), 32'h0);
    csr_write(5'd1, 32'hABCD8000);
    step(); check_all();
    chk("mask_abcd", 32'(exception_mask), 32'hABCD);
    chk("ie_set", 32'(interrupt_enable), 32'h1);

    // IRQ edge capture and write-1-to-clear.
    csr_write(5'd4, 32'h05);
    step();
    irq_lines = 8'h04;
    step(); check_all();
    chk("irq_req_on", 32'(irq_request), 32'h1);
    chk("irq_id_2", 32'(irq_id), 32'h2);
    irq_lines = 8'h00;
    csr_write(5'd5, 32'h04);
    step(); check_all();
    chk("irq_req_off", 32'(irq_request), 32'h0);

    // Nest to full, overflow, then unwind.
    for (int i = 1; i <= 5; i++) begin
      trap_entry = 1'b1; trap_pc = 32'(i * 32'h100); trap_cause = 5'(i);
      step(); check_all();
    end
    bus.read_addr = 5'd7; #1;
    chk("overflow", bus.read_data & 32'h1, 32'h1);
    chk("full_depth", 32'(nest_depth), 32'd4);
    chk("epc_500", epc, 32'h500);
    for (int i = 0; i < 4; i++) begin
      trap_return = 1'b1;
      step(); check_all();
    end
    chk("unwound_epc", epc, 32'h0);
    chk("unwound_depth", 32'(nest_depth), 32'd0);

    // Return on empty stack, then simultaneous entry and return.
    trap_return = 1'b1;
    step(); check_all();
    bus.read_addr = 5'd7; #1;
    chk("underflow", bus.read_data & 32'h2, 32'h2);
    chk("underflow_ie", 32'(interrupt_enable), 32'h1);
    trap_entry = 1'b1; trap_return = 1'b1; trap_pc = 32'h600;
    step(); check_all();
    chk("entry_wins_depth", 32'(nest_depth), 32'd1);

    // Syscall capture ignores exception_pending.
    syscall_en = 1'b1; syscall_num = 6'h2A; exception_pending = 1'b1;
    step();
    bus.read_addr = 5'd3; #1;
    chk("syscall_2a", bus.read_data, 32'h2A);

    // Reset in the middle of a nest.
    trap_entry = 1'b1; trap_pc = 32'h700;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_all();
    chk("reset_mid_nest", 32'(nest_depth), 32'd0);
    read_all();

    for (int c = 0; c < 600; c++) begin
      reset             = ($urandom_range(99) != 0);
      exception_pending = ($urandom_range(7) == 0);
      bus.write_en      = ($urandom_range(3) == 0);
      bus.write_addr    = 5'($urandom_range(9));
      bus.write_data    = $urandom;
      flags_en          = ($urandom_range(2) == 0);
      flags_in          = 4'($urandom);
      syscall_en        = ($urandom_range(4) == 0);
      syscall_num       = 6'($urandom);
      int_en_set        = ($urandom_range(3) == 0);
      int_en_clr        = ($urandom_range(5) == 0);
      trap_entry        = ($urandom_range(5) == 0);
      trap_return       = ($urandom_range(4) == 0);
      trap_cause        = 5'($urandom);
      trap_pc           = $urandom;
      if ($urandom_range(2) == 0) irq_lines = 8'($urandom);
      bus.read_addr     = 5'($urandom_range(9));
      check_all();
      step();
    end
    reset = 1'b1;
    check_all();
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
